// File: rtl/rotary_encoder_emulator_if.sv
`default_nettype none
// ============================================================================
//  Module   : rotary_encoder_emulator_if
//  Brief    : Step-request handshake and quadrature output bundle.
//  Revision : 1.0
// ============================================================================
interface rotary_encoder_emulator_if;
  logic ing_valid;
  logic ing_ready;
  logic ing_direction;
  logic encoder_pin_a;
  logic encoder_pin_b;
  logic egr_done;

  modport master (
    output ing_valid,
    output ing_direction,
    input  ing_ready,
    input  encoder_pin_a,
    input  encoder_pin_b,
    input  egr_done
  );

  modport slave (
    input  ing_valid,
    input  ing_direction,
    output ing_ready,
    output encoder_pin_a,
    output encoder_pin_b,
    output egr_done
  );
endinterface
`default_nettype wire

// File: rtl/rotary_encoder_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : rotary_encoder_emulator
//  Brief    : Turns step requests into Gray-coded A/B quadrature edges.
//  Revision : 1.0
// ============================================================================
module rotary_encoder_emulator #(
  parameter int edge_hold_clk_cnt_p = 1000,
  parameter int edges_per_step_p    = 4
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  rotary_encoder_emulator_if.slave bus
);

  localparam int                HW          = (edge_hold_clk_cnt_p > 1) ? $clog2(edge_hold_clk_cnt_p) : 1;
  localparam int                EW          = $clog2(edges_per_step_p + 1);
  localparam logic [HW-1:0]     c_HOLD_LAST = HW'(edge_hold_clk_cnt_p - 1);
  localparam logic [EW-1:0]     c_ECNT_INIT = EW'(edges_per_step_p - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_STEP = 1'b1
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_dir, w_dir_nxt;
  logic [HW-1:0] r_hold, w_hold_nxt;
  logic [EW-1:0] r_ecnt, w_ecnt_nxt;
  logic          r_pin_a, r_pin_b, w_pin_a_nxt, w_pin_b_nxt;
  logic          r_ready, r_done;
  logic          w_done_nxt;
  logic          w_adv, w_adv_dir;

  // The entry edge is counted at load time, so the edge counter holds the
  // number of edges still to come after the current one.
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_hold_nxt  = r_hold;
    w_ecnt_nxt  = r_ecnt;
    w_adv       = 1'b0;
    w_adv_dir   = r_dir;
    case (r_state)
      S_IDLE: begin
        if (bus.ing_valid) begin
          w_state_nxt = S_STEP;
          w_dir_nxt   = bus.ing_direction;
          w_adv       = 1'b1;
          w_adv_dir   = bus.ing_direction;
          w_hold_nxt  = '0;
          w_ecnt_nxt  = c_ECNT_INIT;
        end
      end
      S_STEP: begin
        if (r_hold == c_HOLD_LAST) begin
          w_hold_nxt = '0;
          if (r_ecnt == '0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_adv      = 1'b1;
            w_ecnt_nxt = r_ecnt - EW'(1);
          end
        end else begin
          w_hold_nxt = r_hold + HW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // CW walks 00->10->11->01, CCW the reverse; one pin flips per edge.
    w_pin_a_nxt = r_pin_a;
    w_pin_b_nxt = r_pin_b;
    if (w_adv) begin
      if (w_adv_dir) begin
        w_pin_a_nxt = ~r_pin_b;
        w_pin_b_nxt = r_pin_a;
      end else begin
        w_pin_a_nxt = r_pin_b;
        w_pin_b_nxt = ~r_pin_a;
      end
    end

    // Registered done: flag the upcoming final hold cycle one edge early.
    w_done_nxt = (w_state_nxt == S_STEP) && (w_ecnt_nxt == '0) && (w_hold_nxt == c_HOLD_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_dir   <= 1'b0;
      r_hold  <= '0;
      r_ecnt  <= '0;
      r_pin_a <= 1'b0;
      r_pin_b <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_hold  <= w_hold_nxt;
      r_ecnt  <= w_ecnt_nxt;
      r_pin_a <= w_pin_a_nxt;
      r_pin_b <= w_pin_b_nxt;
      r_ready <= (w_state_nxt == S_IDLE);
      r_done  <= w_done_nxt;
    end
  end

  assign bus.ing_ready     = r_ready;
  assign bus.encoder_pin_a = r_pin_a;
  assign bus.encoder_pin_b = r_pin_b;
  assign bus.egr_done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_rotary_encoder_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rotary_encoder_emulator
//  Brief    : Two emulator instances (H=3/E=4 and H=2/E=2) against a timing model.
//  Revision : 1.0
// ============================================================================
module tb_rotary_encoder_emulator;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rotary_encoder_emulator_if if0 ();
  rotary_encoder_emulator_if if1 ();

  rotary_encoder_emulator #(.edge_hold_clk_cnt_p(3), .edges_per_step_p(4)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  rotary_encoder_emulator #(.edge_hold_clk_cnt_p(2), .edges_per_step_p(2)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: per instance, the step in flight is fully described by its start
  // cycle, direction and start phase; outputs follow from elapsed cycles.
  int m_E [2] = '{4, 2};
  int m_H [2] = '{3, 2};
  bit m_busy [2];
  int m_T [2];
  int m_p0 [2];
  int m_prest [2];
  bit m_dir [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [1:0] pins_of(input int p);
    case (p)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic int phase_after(input int p, input bit dir, input int n);
    return ((p + (dir ? n : -n)) % 4 + 4) % 4;
  endfunction

  task automatic model_eval(input int d, output logic [1:0] pins, output logic rdy, output logic dn);
    int k;
    int n;
    if (m_busy[d] && (cyc - m_T[d]) > m_E[d] * m_H[d]) begin
      m_busy[d]  = 1'b0;
      m_prest[d] = phase_after(m_p0[d], m_dir[d], m_E[d]);
    end
    if (!m_busy[d]) begin
      pins = pins_of(m_prest[d]);
      rdy  = 1'b1;
      dn   = 1'b0;
    end else begin
      k    = cyc - m_T[d];
      n    = (k - 1) / m_H[d] + 1;
      pins = pins_of(phase_after(m_p0[d], m_dir[d], n));
      rdy  = 1'b0;
      dn   = (k == m_E[d] * m_H[d]);
    end
  endtask

  task automatic check_outputs();
    logic [1:0] ep;
    logic       er, ed;
    logic [3:0] o [2];
    o[0] = {if0.encoder_pin_a, if0.encoder_pin_b, if0.ing_ready, if0.egr_done};
    o[1] = {if1.encoder_pin_a, if1.encoder_pin_b, if1.ing_ready, if1.egr_done};
    for (int d = 0; d < 2; d++) begin
      model_eval(d, ep, er, ed);
      chk($sformatf("d%0d_pins_ab", d), 32'(o[d][3:2]), 32'(ep));
      chk($sformatf("d%0d_ready", d),   32'(o[d][1]),   32'(er));
      chk($sformatf("d%0d_done", d),    32'(o[d][0]),   32'(ed));
    end
  endtask

  task automatic cycle_step(input logic v, input logic dir, output logic hs0);
    @(negedge clk);
    check_outputs();
    if0.ing_valid     = v;
    if1.ing_valid     = v;
    if0.ing_direction = dir;
    if1.ing_direction = dir;
    hs0 = 1'b0;
    for (int d = 0; d < 2; d++) begin
      if (v && rst_n && !m_busy[d]) begin
        m_busy[d] = 1'b1;
        m_T[d]    = cyc;
        m_dir[d]  = dir;
        m_p0[d]   = m_prest[d];
        if (d == 0) hs0 = 1'b1;
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_d0"}, 32'({if0.encoder_pin_a, if0.encoder_pin_b, if0.ing_ready, if0.egr_done}), 32'h2);
    chk({tag, "_d1"}, 32'({if1.encoder_pin_a, if1.encoder_pin_b, if1.ing_ready, if1.egr_done}), 32'h2);
  endtask

  task automatic reset_mid_step();
    logic hs;
    while (m_busy[0]) cycle_step(1'b0, 1'b0, hs);
    cycle_step(1'b1, 1'($urandom_range(0, 1)), hs);
    repeat (4) cycle_step(1'b0, 1'b0, hs);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    for (int d = 0; d < 2; d++) begin
      m_busy[d]  = 1'b0;
      m_prest[d] = 0;
    end
    repeat (3) cycle_step(1'b0, 1'b0, hs);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic hs;
    logic dir;
    for (int d = 0; d < 2; d++) begin
      m_busy[d]  = 1'b0;
      m_prest[d] = 0;
      m_T[d]     = 0;
      m_p0[d]    = 0;
      m_dir[d]   = 1'b0;
    end
    rst_n             = 1'b0;
    if0.ing_valid     = 1'b0;
    if1.ing_valid     = 1'b0;
    if0.ing_direction = 1'b0;
    if1.ing_direction = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_reset_values("reset");
    rst_n = 1'b1;

    repeat (50) cycle_step(1'b0, 1'b0, hs);

    cycle_step(1'b1, 1'b1, hs);
    repeat (15) cycle_step(1'b0, 1'b0, hs);
    cycle_step(1'b1, 1'b0, hs);
    repeat (15) cycle_step(1'b0, 1'b0, hs);

    // Valid held high with direction flipped after every accepted request.
    dir = 1'b1;
    repeat (45) begin
      cycle_step(1'b1, dir, hs);
      if (hs) dir = ~dir;
    end
    repeat (20) cycle_step(1'b0, 1'b0, hs);

    reset_mid_step();
    repeat (40) cycle_step(1'b1, 1'b1, hs);

    repeat (1500) cycle_step(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), hs);

    reset_mid_step();
    repeat (300) cycle_step(($urandom_range(0, 1) == 0), 1'($urandom_range(0, 1)), hs);
    repeat (20) cycle_step(1'b0, 1'b0, hs);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
